// File: rtl/cnn16_pkg.sv
// ---------------------------------------------------------------------------
// cnn16_pkg
// Shared definitions for the CNN16 block-RAM initiators.
//   DATA_WIDTH / ADDR_WIDTH : RAM geometry, shared with cnn16_ram
//   reader_state_e          : state encoding of cnn16_ram_reader
//   fifo_entry_t            : one buffered word plus its end-of-job flag
// ---------------------------------------------------------------------------
package cnn16_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } reader_state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/cnn16_sync_fifo.sv
// ---------------------------------------------------------------------------
// cnn16_sync_fifo
// Show-ahead synchronous FIFO: rd_data always shows the head entry, and
// rd_en pops it. Writing while full is an upstream error and is flagged by
// an assertion; the write is dropped.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : push wr_data
//   wr_data   : entry to push
//   rd_en     : pop head (ignored when empty)
//   rd_data   : current head entry
//   empty     : no entries held
//   count     : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cnn16_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && !full;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (PW+1)'(do_wr) - (PW+1)'(do_rd);
        if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it is written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/cnn16_ram_reader.sv
// ---------------------------------------------------------------------------
// cnn16_ram_reader
// Read-side initiator for the CNN16 16-bit block RAM. Walks a strided
// address window, captures RAM data after RD_LAT cycles into a show-ahead
// FIFO, and streams the words out with an end-of-job marker.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : launch request, only looked at in IDLE
//   base_addr       : first read address
//   count           : words to read, 0..2^ADDR_WIDTH
//   stride          : address increment per word (wraps modulo 2^ADDR_WIDTH)
//   busy            : high from the accepted start until the done cycle
//   done            : one-cycle end-of-job pulse
//   mem_write       : RAM write enable, tied low
//   address         : registered RAM address
//   mem_rdata       : RAM read data
//   m_valid/m_ready : output stream handshake
//   m_data, m_last  : stream word and end-of-job flag
//   stall_cycles    : (CNN16_READER_PERF_EN only) backpressure cycle count
//   dbg_state       : current FSM state
// Handshake: a word moves when m_valid && m_ready on a rising edge; while
// m_valid && !m_ready, m_data and m_last hold their values.
// Build option: define CNN16_READER_PERF_EN to add the stall_cycles counter.
// ---------------------------------------------------------------------------
module cnn16_ram_reader
    import cnn16_pkg::*;
#(
    parameter int DATA_WIDTH = cnn16_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cnn16_pkg::ADDR_WIDTH,
    parameter int RD_LAT     = 1,  // 1..2
    parameter int FIFO_DEPTH = 4   // power of two, >= RD_LAT+2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef CNN16_READER_PERF_EN
    output logic [31:0]           stall_cycles,
`endif
    output reader_state_e         dbg_state,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int IFW = $clog2(RD_LAT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int CRW = FCW + 1;

    reader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
    logic [IFW-1:0]        in_flight_q, in_flight_d;
    logic [RD_LAT-1:0]     vld_sr_q, vld_sr_d;
    logic [RD_LAT-1:0]     last_sr_q, last_sr_d;

    logic                  start_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  capture;
    logic                  xfer;
    logic                  credit_ok;
    fifo_entry_t           wr_entry;
    fifo_entry_t           head;
    logic                  fifo_empty;
    logic [FCW-1:0]        fifo_count;

    assign start_ok   = (state_q == IDLE) && start;
    assign capture    = vld_sr_q[RD_LAT-1];
    assign issue_last = (issued_q == count_q - (ADDR_WIDTH+1)'(1));
    // Reads already launched plus words already buffered must leave room,
    // so every in-flight word is guaranteed a FIFO slot on arrival.
    assign credit_ok  = (CRW'(in_flight_q) + CRW'(fifo_count)) < CRW'(FIFO_DEPTH);

    // FSM next state and datapath control
    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        stride_d   = stride_q;
        count_d    = count_q;
        issued_d   = issued_q;
        accepted_d = accepted_q + (ADDR_WIDTH+1)'(xfer);
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = count;
                    stride_d   = stride;
                    issued_d   = '0;
                    accepted_d = '0;
                    if (count == '0) begin
                        // Empty job: leave the RAM address untouched.
                        state_d = FINISH;
                    end else begin
                        address_d = base_addr;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if ((issued_q < count_q) && credit_ok) begin
                    issue     = 1'b1;
                    address_d = address_q + stride_q;
                    issued_d  = issued_q + (ADDR_WIDTH+1)'(1);
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((in_flight_q == '0) && fifo_empty && (accepted_q == count_q))
                    state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In-flight tracking: one slot per cycle of RAM latency.
    always_comb begin
        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = issue;
        last_sr_d[0] = issue && issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
        in_flight_d = in_flight_q + IFW'(issue) - IFW'(capture);
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.last = last_sr_q[RD_LAT-1];
        wr_entry.data = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            address_q   <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            in_flight_q <= '0;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            stride_q    <= stride_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            accepted_q  <= accepted_d;
            in_flight_q <= in_flight_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
        end
    end

    cnn16_sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (wr_entry),
        .rd_en   (xfer),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid   = !fifo_empty;
    assign xfer      = m_valid && m_ready;
    // Zero the stream outputs when nothing is buffered so they read 0 out of reset.
    assign m_data    = m_valid ? head.data : '0;
    assign m_last    = m_valid && head.last;

    // busy rises combinationally with the accepted start, drops in FINISH.
    assign busy      = start_ok || (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == FINISH);
    assign mem_write = 1'b0;
    assign address   = address_q;
    assign dbg_state = state_q;

`ifdef CNN16_READER_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok)
            stall_d = '0;
        else if (busy && m_valid && !m_ready)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cnn16_ram_reader.sv
module tb_cnn16_ram_reader;
  import cnn16_pkg::*;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        start;
  logic [11:0] base_addr;
  logic [12:0] count;
  logic [11:0] stride;
  logic        busy;
  logic        done;
  logic        mem_write;
  logic [11:0] address;
  logic [15:0] mem_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  reader_state_e dbg_state;
`ifdef CNN16_READER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  cnn16_ram_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .count        (count),
    .stride       (stride),
    .busy         (busy),
    .done         (done),
    .mem_write    (mem_write),
    .address      (address),
    .mem_rdata    (mem_rdata),
`ifdef CNN16_READER_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .dbg_state    (dbg_state),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  // RAM model: one-cycle registered read, mem[i] = i*3
  logic [15:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i * 3);
  end
  always @(posedge clk) mem_rdata <= ram[address];

  // scoreboard
  logic [16:0] exp_q[$];
  int vectors;
  int miscompares;
  int stall_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_addr(input logic [11:0] b, input logic [11:0] s, input int i);
    return 12'((int'(b) + i * int'(s)) % 4096);
  endfunction

  // mode 0: always ready; mode 1: 1,0,0,1 repeating with a 10-cycle hold-off
  function automatic logic ready_for(input int mode, input int k);
    int idx;
    logic r;
    idx = k - 1;
    if (mode == 0) return 1'b1;
    case (idx % 4)
      0: r = 1'b1;
      1: r = 1'b0;
      2: r = 1'b0;
      default: r = 1'b1;
    endcase
    if (idx >= 6 && idx < 16) r = 1'b0;
    return r;
  endfunction

  // driver + monitor for one job; inputs driven and outputs sampled on negedges
  task automatic run_job(input logic [11:0] base, input logic [12:0] cnt, input logic [11:0] strd,
                         input int mode, input logic chk_time, input logic inject,
                         input logic [11:0] alt_base);
    int k;
    logic rdy;
    logic held;
    logic [15:0] held_data;
    logic held_last;
    logic done_seen;
    logic [16:0] e;
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++)
      exp_q.push_back({(i == int'(cnt) - 1), ram[exp_addr(base, strd, i)]});
    stall_exp = 0;
    held = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    count = cnt;
    stride = strd;
    m_ready = 1'b1;
    #1;
    check("busy_on_start", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < int'(cnt) + 400) begin
      check("mem_write", mem_write, 1'b0);
      if (chk_time && k <= int'(cnt)) check("address", address, exp_addr(base, strd, k - 1));
      if (chk_time && k == 2) check("valid_early", m_valid, 1'b0);
      if (chk_time && k == 3) check("first_valid", m_valid, 1'b1);
      if (held) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, held_data);
        check("hold_last", m_last, held_last);
      end
      if (done) begin
        done_seen = 1'b1;
        check("busy_at_done", busy, 1'b0);
        check("state_finish", dbg_state, FINISH);
        check("words_left", exp_q.size(), 0);
`ifdef CNN16_READER_PERF_EN
        check("stall_cycles", stall_cycles, stall_exp);
`endif
        break;
      end
      check("busy", busy, 1'b1);
      rdy = ready_for(mode, k);
      m_ready = rdy;
      if (inject && k == 4) begin
        start = 1'b1;
        base_addr = alt_base;
      end else if (inject && k == 5) begin
        start = 1'b0;
      end
      if (busy && m_valid && !rdy) stall_exp++;
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", m_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[15:0]);
          check("m_last", m_last, e[16]);
        end
      end
      held = m_valid && !rdy;
      held_data = m_data;
      held_last = m_last;
      @(negedge clk);
      k++;
    end
    check("done_seen", done_seen, 1'b1);
    start = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("valid_after", m_valid, 1'b0);
    check("state_idle", dbg_state, IDLE);
`ifdef CNN16_READER_PERF_EN
    check("stall_hold", stall_cycles, stall_exp);
`endif
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_address", address, 12'h000);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_m_last", m_last, 1'b0);
    check("rst_state", dbg_state, IDLE);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    stride = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // basic read: 0x010..0x013 -> 0x0030, 0x0033, 0x0036, 0x0039
    run_job(12'h010, 13'd4, 12'd1, 0, 1'b1, 1'b0, 12'h000);

    // stride and wrap: 0xFFE, 0x000, 0x002
    run_job(12'hFFE, 13'd3, 12'd2, 0, 1'b1, 1'b0, 12'h000);

    // backpressure with a long hold-off
    run_job(12'h040, 13'd8, 12'd3, 1, 1'b0, 1'b0, 12'h000);

    // zero length: address keeps 0x040 + 8*3 = 0x058
    run_job(12'h555, 13'd0, 12'd1, 0, 1'b0, 1'b0, 12'h000);
    check("zero_len_address", address, 12'h058);

    // full window: address wraps back to base after 4096 issues
    run_job(12'h123, 13'd4096, 12'd1, 0, 1'b0, 1'b0, 12'h000);
    check("wrap_4096_address", address, 12'h123);

    // reset on the 3rd beat of a 16-word job
    @(negedge clk);
    start = 1'b1;
    base_addr = 12'h100;
    count = 13'd16;
    stride = 12'd1;
    m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("beat3_valid", m_valid, 1'b1);
    check("beat3_data", m_data, 16'h0306);
    rst = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();
    // fresh job: 0x200 -> 0x0600, 0x205 -> 0x060F
    run_job(12'h200, 13'd2, 12'd5, 0, 1'b1, 1'b0, 12'h000);

    // start while busy is ignored
    run_job(12'h300, 13'd6, 12'd1, 1, 1'b0, 1'b1, 12'h7AB);
    check("after_inject_address", address, 12'h306);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
